// File: rtl/pipo_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin PIPO scheduler.
package pipo_pkg;

    // Scheduler states: waiting for a request, or holding a freshly loaded word.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Index width for a count of m items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/n_pipo.sv
// N-bit parallel-in/parallel-out register with asynchronous active-low reset.
// Loads d on every rising edge; callers build hold behaviour with a mux on d.
module n_pipo #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Plain storage element, cleared to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipo_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from M-1 back to 0.
module rr_pick
    import pipo_pkg::*;
#(
    parameter int M = 4,
    parameter int W = idx_width(M)
) (
    input  logic [M-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W:0] pos;

    // Scan from farthest to nearest so the closest pending requester wins last.
    always_comb begin
        winner = '0;
        pos    = '0;
        any    = |req;
        for (int k = M - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (W + 1)'(k);
            if (pos >= (W + 1)'(M)) begin
                pos = pos - (W + 1)'(M);
            end
            if (req[pos[W-1:0]]) begin
                winner = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/pipo_rr_scheduler.sv
// Round-robin scheduler: the only writer of a shared N-bit PIPO register.
// Each arbitration loads the winner's word, pulses its grant for one cycle
// and then ignores requests for HOLD cycles before arbitrating again.
//
// Handshake: a requester raises req[i] with stable data and keeps both until
// gnt[i] is seen high; gnt[i] high for one cycle means the word is now in q.
module pipo_rr_scheduler
    import pipo_pkg::*;
#(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int HOLD = 2,
    localparam int W     = idx_width(M),
    localparam int CNT_W = idx_width(HOLD)
) (
    input  logic           clk,
    input  logic           clear,
    input  logic [M-1:0]   req,
    input  logic [M*N-1:0] data_in,
    output logic [M-1:0]   gnt,
    output logic [N-1:0]   q,
    output logic [W-1:0]   q_owner,
    output logic           q_valid,
    output logic           busy
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     ptr_q;
    logic [M-1:0]     gnt_q;
    logic [W-1:0]     owner_q;
    logic             valid_q;

    logic [W-1:0]     win;
    logic             any;
    logic             load;
    logic [W-1:0]     ptr_d;
    logic [M-1:0]     win_onehot;
    logic [N-1:0]     win_slice;
    logic [N-1:0]     pipo_d;

    rr_pick #(
        .M (M),
        .W (W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win),
        .any    (any)
    );

    // A load happens only on an arbitration edge with something pending.
    assign load = (state_q == ST_IDLE) && any;

    // Winner's data slice, one-hot grant and the pointer just past the winner.
    always_comb begin
        win_slice  = '0;
        win_onehot = '0;
        for (int i = 0; i < M; i++) begin
            if (win == W'(i)) begin
                win_slice     = data_in[i*N +: N];
                win_onehot[i] = 1'b1;
            end
        end
        ptr_d  = (win == W'(M - 1)) ? '0 : win + 1'b1;
        pipo_d = load ? win_slice : q;
    end

    n_pipo #(
        .N (N)
    ) u_pipo (
        .clk   (clk),
        .rst_n (clear),
        .d     (pipo_d),
        .q     (q)
    );

    // Scheduler FSM with hold counter, pointer and registered grant/owner.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CNT_W'(HOLD - 1);
                        ptr_q   <= ptr_d;
                        gnt_q   <= win_onehot;
                        owner_q <= win;
                        valid_q <= 1'b1;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    gnt_q <= '0;
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign q_owner = owner_q;
    assign q_valid = valid_q;
    assign busy    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pipo_rr_scheduler.sv
// Bench for pipo_rr_scheduler with N=4, M=4, HOLD=2.
module tb_pipo_rr_scheduler;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int HOLD = 2;
    localparam int W    = 2;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           clear;
    logic [M-1:0]   req;
    logic [M*N-1:0] data_in;
    logic [M-1:0]   gnt;
    logic [N-1:0]   q;
    logic [W-1:0]   q_owner;
    logic           q_valid;
    logic           busy;

    always #5 clk = ~clk;

    pipo_rr_scheduler #(
        .N    (N),
        .M    (M),
        .HOLD (HOLD)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .q       (q),
        .q_owner (q_owner),
        .q_valid (q_valid),
        .busy    (busy)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {owner[1:0], q[3:0], gnt[3:0]}
    logic [W+N+M-1:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_grant(input int owner, input logic [N-1:0] data);
        logic [M-1:0] oh;
        oh = '0;
        oh[owner] = 1'b1;
        exp_q.push_back({W'(owner), data, oh});
    endtask

    // Monitor: every observed grant must match the oldest expected load.
    always @(negedge clk) begin
        if (gnt !== '0) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_grant: got gnt=%b q=%b owner=%0d, expected none at %0t",
                         gnt, q, q_owner, $time);
            end else begin
                logic [W+N+M-1:0] e;
                e = exp_q.pop_front();
                check("grant_owner_q_gnt", {30'(q_owner), q, gnt}, 32'(e));
                check("grant_q_valid", 32'(q_valid), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_slice(input int i, input logic [N-1:0] v);
        data_in[i*N +: N] = v;
    endtask

    // One cycle; a requester withdraws once it sees its grant.
    task automatic step();
        @(posedge clk);
        #1;
        req = req & ~gnt;
    endtask

    // Run until every request is served and the scheduler is idle.
    task automatic drain(input int budget);
        int n;
        n = 0;
        step();
        while (((req != '0) || busy) && (n < budget)) begin
            step();
            n++;
        end
        check("drain_done", {31'(req), busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_q"}, 32'(q), 32'd0);
        check({tag, "_owner"}, 32'(q_owner), 32'd0);
        check({tag, "_valid"}, 32'(q_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req   = '0;
        clear = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [M-1:0] exp_g;
        logic [N-1:0] held_q;

        // 1. Reset with every requester pending
        clear   = 1'b0;
        req     = 4'b1111;
        data_in = 16'h8421;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        req = '0;
        clear = 1'b1;

        // 2. Single request, one-cycle latency, busy for HOLD cycles
        set_slice(2, 4'b1010);
        req = 4'b0100;
        expect_grant(2, 4'b1010);
        step();
        check("single_gnt", 32'(gnt), 32'b0100);
        check("single_busy0", 32'(busy), 32'd1);
        step();
        check("single_busy1", 32'(busy), 32'd1);
        check("single_gnt_low", 32'(gnt), 32'd0);
        step();
        check("single_busy_end", 32'(busy), 32'd0);
        set_slice(0, 4'b0111);
        req = 4'b0001;
        expect_grant(0, 4'b0111);
        step();
        check("single_next_gnt", 32'(gnt), 32'b0001);
        drain(20);

        // 3. Continuous full load: grants 0,1,2,3,0 every HOLD+1 cycles
        do_reset();
        set_slice(0, 4'b0001);
        set_slice(1, 4'b0010);
        set_slice(2, 4'b0100);
        set_slice(3, 4'b1000);
        req = 4'b1111;
        expect_grant(0, 4'b0001);
        expect_grant(1, 4'b0010);
        expect_grant(2, 4'b0100);
        expect_grant(3, 4'b1000);
        expect_grant(0, 4'b0001);
        for (int c = 0; c < 13; c++) begin
            @(posedge clk);
            #1;
            exp_g = '0;
            if (c % 3 == 0) exp_g[(c / 3) % 4] = 1'b1;
            check("full_spacing", 32'(gnt), 32'(exp_g));
        end
        req = '0;
        drain(20);

        // 4. Pointer wrap: grant 2 leaves ptr at 3, then 0 beats 2
        set_slice(2, 4'b1100);
        req = 4'b0100;
        expect_grant(2, 4'b1100);
        drain(20);
        set_slice(0, 4'b0011);
        req = 4'b0101;
        expect_grant(0, 4'b0011);
        expect_grant(2, 4'b1100);
        drain(30);

        // 5. Reset asserted mid-HOLD
        set_slice(0, 4'b0101);
        req = 4'b0001;
        expect_grant(0, 4'b0101);
        step();
        check("midhold_busy_a", 32'(busy), 32'd1);
        step();
        check("midhold_busy_b", 32'(busy), 32'd1);
        #1;
        clear = 1'b0;
        #1;
        check_reset_outputs("midhold_reset");
        set_slice(0, 4'b0110);
        set_slice(3, 4'b1111);
        req = 4'b1001;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midhold_no_gnt", {30'(gnt), q_valid, busy}, 32'd0);
        expect_grant(0, 4'b0110);
        expect_grant(3, 4'b1111);
        clear = 1'b1;
        drain(30);

        // 6. Request raised and dropped entirely inside HOLD
        set_slice(3, 4'b1001);
        req = 4'b1000;
        expect_grant(3, 4'b1001);
        step();
        check("inhold_busy_a", 32'(busy), 32'd1);
        held_q = 4'b1001;
        set_slice(1, 4'b0110);
        req = 4'b0010;
        step();
        check("inhold_busy_b", 32'(busy), 32'd1);
        req = '0;
        repeat (4) step();
        check("inhold_q", 32'(q), 32'(held_q));
        check("inhold_owner", 32'(q_owner), 32'd3);
        check("inhold_idle", {30'(gnt), busy}, 32'd0);

        // Wrap-up: every expected grant must have been observed
        repeat (3) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipo_rr_scheduler.md
# pipo_rr_scheduler

Round-robin scheduler sharing one N-bit parallel-in/parallel-out register among M requesters. Each cycle in which the register is free, it picks one pending requester. It loads that requester's data word into the register and holds the value for a programmable number of cycles before re-arbitrating. It sits between several producer blocks and the shared PIPO storage, and is the only writer of that storage.

## Interface
- `N`, 4: data width of the shared register.
- `M`, 4: number of requesters, ≥2.
- `HOLD`, 2: cycles a loaded value is held before the next arbitration, ≥1.

- `clk` in 1: single clock, rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `req` in M: per-requester load request, level. Must stay high with its data stable until its `gnt` is seen.
- `data_in` in M*N: requester i's word is at bits [i*N +: N].
- `gnt` out M: one-hot, high for exactly one cycle when that requester's word has been loaded.
- `q` out N: shared register contents.
- `q_owner` out clog2(M): index of the requester whose word is in `q`.
- `q_valid` out 1: high once any word has been loaded since reset (sticky).
- `busy` out 1: high while in HOLD.

## Operation
- FSM states are IDLE and HOLD.
- IDLE, `req`==0: nothing changes.
- IDLE, `req`!=0, at the clock edge:
  - Winner w is the first set bit of `req` searching upward from `ptr`, wrapping at M−1→0.
  - `q`<=slice w, `q_owner`<=w, `q_valid`<=1, `gnt`<=onehot(w).
  - `ptr`<=(w+1) mod M.
  - Down-counter `cnt`<=HOLD−1, state<=HOLD.
- HOLD, at each edge:
  - `gnt`<=0.
  - If `cnt`==0, state<=IDLE; otherwise `cnt`<=`cnt`−1.
  - `req` is ignored; `q` and `q_owner` hold.
- `busy` = (state==HOLD), decoded directly from state.
- `ptr` only advances on a grant. The same requester can win consecutive grants only if no other requester is pending.
- Reset values (while `clear` is low, regardless of clock): state IDLE, `ptr` 0, `cnt` 0, `gnt` 0, `q` 0, `q_owner` 0, `q_valid` 0, `busy` 0.
- Reset asserted mid-HOLD: the operation is abandoned immediately, with no partial load or grant afterwards.

## Timing
- Request to load: req sampled at IDLE edge E. `q`, `q_owner`, `gnt` and `busy` are valid in the cycle after E, so latency is 1 cycle.
- `gnt` is high for the cycle after E only. The requester may drop `req` at edge E+1.
- State returns to IDLE at edge E+HOLD. The next arbitration edge is E+HOLD+1.
- Grant spacing under continuous requests is HOLD+1 cycles.
- A `req` raised and dropped entirely inside HOLD is never granted.
- Register update, `gnt` and `ptr` change on the same edge. There is no combinational path from `req` to `q`.
- Release of `clear` is treated as synchronous to `clk` by the integrator. The block adds no synchronizer.

## Structure
- Shared package `pipo_pkg`:
  - state enum {IDLE, HOLD}.
  - width function for clog2(M), used for `ptr` and `q_owner`.
- One sub-module, `rr_pick`: combinational. Inputs are `req` and `ptr`; outputs are winner index and `any`.
- The top holds the FSM, `cnt`, `ptr` and the N-bit register with load enable. Storage reuses `n_pipo` with a hold-feedback mux in front of `d`.

## Test plan
All scenarios use N=4, M=4, HOLD=2.
1. Reset: drive `clear`=0 with `req`=1111 → `gnt`=0000, `q`=0000, `q_owner`=0, `q_valid`=0, `busy`=0.
2. Single request: `req`=0100, data slice 2=1010 → next cycle `gnt`=0100, `q`=1010, `q_owner`=2, `q_valid`=1. `busy` is high for 2 cycles, then the next grant edge follows.
3. Full load: `req`=1111 held continuously after reset, slices 0..3 = 0001, 0010, 0100, 1000 → grants 0,1,2,3,0 every 3 cycles, with `q` following the slices.
4. Pointer wrap: after a grant to requester 2 (`ptr`=3), drive `req`=0101 → requester 0 is granted before requester 2.
5. Reset mid-HOLD: pulse `clear` low during HOLD → outputs return to reset values immediately. After release with `req`=1001, requester 0 is granted first.
6. Request inside HOLD: raise `req`=0010 only during HOLD cycles → no `gnt`, and `q` is unchanged.
